golden_nonce_fifo: RTL and testbench
====================================

# golden_nonce_fifo

Downstream capture stage for the double-hash miner core: watches the miner's registered second-hash word and its aligned nonce, and pushes every nonce whose hash word matches the target into a small FIFO. The host-side interface logic drains the FIFO, so hits arriving back-to-back or while the host is busy are never collapsed into one register. The block also keeps hit, drop and overflow statistics for the host.

## Interface
- `DEPTH`, default 8: FIFO entries; power of two, 2..64.
- `AW`, default 3: log2(DEPTH); pointer width.
- `MATCH_VALUE`, default 32'ha41f32e7: hash2 value that marks a golden nonce.
- `clk` in 1: sole clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-low; low at a rising edge resets all state.
- `hash2` in 32: registered hash word from the miner core.
- `nonce2` in 32: nonce aligned with `hash2` in the same cycle.
- `clear` in 1: synchronous flush strobe (see Operation).
- `rd_en` in 1: pop strobe from host logic.
- `dout` out 32: head entry (first-word-fall-through); valid only while `empty`=0.
- `empty` out 1: FIFO holds no entries.
- `full` out 1: FIFO holds DEPTH entries.
- `count` out AW+1: current occupancy, 0..DEPTH.
- `overflow` out 1: sticky; a hit was dropped because the FIFO was full.
- `drop_count` out 8: dropped hits, saturates at 255.
- `hit_count` out 32: total matches seen, wraps modulo 2^32.

## Operation
- Hit: `hash2 == MATCH_VALUE`, evaluated combinationally each cycle; the push is qualified as described in Configuration.
- Storage: DEPTH x 32 memory, write pointer `wp`, read pointer `rp`, both AW bits, wrapping naturally; occupancy counter `count`.
- Push: a qualified hit with `full`=0 writes `nonce2` at `wp`; `wp` increments.
- Pop: `rd_en`=1 with `empty`=0 increments `rp`; `rd_en` while empty is ignored, with no state change.
- Simultaneous push and pop: both take effect and `count` is unchanged. This holds when full: the pop frees a slot, the push is accepted, and no drop is recorded.
- Full with push and no pop: the entry is discarded, `overflow` is set, and `drop_count` increments unless it is already 255.
- `hit_count` increments on every qualified hit, whether it was stored or dropped.
- `clear`=1: `wp`, `rp` and `count` go to 0; `overflow` and `drop_count` are cleared. A push or pop in the same cycle is discarded. `hit_count` is preserved.
- Reset (low): `wp`, `rp`, `count`, `overflow`, `drop_count` and `hit_count` go to 0. Reset overrides `clear`, push and pop. Memory contents are don't-care.
- Reset values: `empty`=1, `full`=0, `count`=0, `overflow`=0, `drop_count`=0, `hit_count`=0. `dout` is undefined while empty.
- `empty` = (count==0). `full` = (count==DEPTH). Both are derived from registered `count`.

## Timing
- Push latency: a hit sampled at edge N is visible at edge N: after that edge, `empty`=0 and `dout` equals the nonce.
- `dout` shows `mem[rp]` combinationally. After a pop at edge N, the next entry appears after edge N.
- Back-to-back hits on consecutive cycles are each stored, one per cycle.
- Statistics outputs update on the same edge as the event that changes them.
- No combinational path exists from `rd_en` to `empty`/`full`/`count`. These outputs change only at clock edges.

## Configuration
- Macro `GOLDEN_NONCE_FIFO_DEDUP_EN`.
- Defined: a last-pushed-nonce register plus a valid bit; both are reset or cleared to invalid. A hit whose `nonce2` equals the last accepted nonce while the bit is valid is not qualified: no push, no `hit_count` increment, no drop. This guards against a matching `hash2` being held across cycles.
- Not defined: every cycle with a match is a qualified hit, including repeats of the same nonce.

## Test plan
- Reset: hold `reset`=0 for 2 cycles -> `empty`=1, `count`=0, `overflow`=0, `drop_count`=0, `hit_count`=0.
- Single hit: `hash2`=32'ha41f32e7, `nonce2`=32'h00001234 for 1 cycle -> next cycle `empty`=0, `dout`=32'h00001234, `count`=1, `hit_count`=1. `rd_en` for 1 cycle -> `empty`=1.
- Fill and overflow (DEPTH=8): 10 consecutive hits, nonces 1..10, no reads -> `full`=1, `count`=8, `overflow`=1, `drop_count`=2, `hit_count`=10. Draining reads 1..8 in order.
- Push and pop at full: FIFO full with 1..8, then a hit with nonce 9 plus `rd_en` -> `count`=8, `overflow`=0. Draining reads 2..9.
- Clear and wrap: after the pointers have wrapped twice, assert `clear` with a simultaneous hit -> `count`=0, `empty`=1, `drop_count`=0, `hit_count` unchanged, hit not stored.
- Dedup: hold a match with `nonce2`=32'hdeadbeef for 3 cycles -> with `GOLDEN_NONCE_FIFO_DEDUP_EN`: `count`=1, `hit_count`=1. Without it: `count`=3, `hit_count`=3.

Source files
------------

// File: rtl/golden_nonce_fifo.sv
// Golden-nonce capture FIFO: stores every nonce whose hash2 matches MATCH_VALUE
// and keeps hit/drop/overflow statistics. Optional GOLDEN_NONCE_FIFO_DEDUP_EN suppresses repeated nonces.
module golden_nonce_fifo #(
   parameter int          DEPTH       = 8,
   parameter int          AW          = 3,
   parameter logic [31:0] MATCH_VALUE = 32'ha41f32e7
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [31:0]   hash2,
   input  logic [31:0]   nonce2,
   input  logic          clear,
   input  logic          rd_en,
   output logic [31:0]   dout,
   output logic          empty,
   output logic          full,
   output logic [AW:0]   count,
   output logic          overflow,
   output logic [7:0]    drop_count,
   output logic [31:0]   hit_count
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic          hit, qual, pop, push_ok, drop;

   assign hit = (hash2 == MATCH_VALUE);

`ifdef GOLDEN_NONCE_FIFO_DEDUP_EN
   // A hash2 match held across cycles would otherwise re-push the same nonce.
   logic [31:0] last_nonce;
   logic        last_vld;

   assign qual = hit && !(last_vld && (nonce2 == last_nonce));

   always_ff @(posedge clk) begin
      if (!reset || clear) begin
         last_vld   <= 1'b0;
         last_nonce <= '0;
      end else if (push_ok) begin
         last_vld   <= 1'b1;
         last_nonce <= nonce2;
      end
   end
`else
   assign qual = hit;
`endif

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign pop     = rd_en && !empty;
   // At full, a same-cycle pop frees the slot the push needs.
   assign push_ok = qual && (!full || pop);
   assign drop    = qual && full && !pop;

   always_ff @(posedge clk) begin
      if (reset && !clear && push_ok) mem[wp] <= nonce2;
   end

   assign dout = mem[rp];

   always_ff @(posedge clk) begin
      if (!reset) begin
         wp         <= '0;
         rp         <= '0;
         count      <= '0;
         overflow   <= 1'b0;
         drop_count <= '0;
         hit_count  <= '0;
      end else if (clear) begin
         wp         <= '0;
         rp         <= '0;
         count      <= '0;
         overflow   <= 1'b0;
         drop_count <= '0;
      end else begin
         if (push_ok) wp <= wp + AW'(1);
         if (pop)     rp <= rp + AW'(1);
         case ({push_ok, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
         if (qual) hit_count <= hit_count + 32'd1;
         if (drop) begin
            overflow <= 1'b1;
            if (drop_count != 8'hff) drop_count <= drop_count + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_golden_nonce_fifo.sv
// Scoreboard bench for golden_nonce_fifo: stimulus queues expected nonces,
// a negedge monitor checks dout on every accepted pop.
module tb_golden_nonce_fifo;

   localparam logic [31:0] MV = 32'ha41f32e7;

   logic        clk = 1'b0;
   logic        reset, clear, rd_en;
   logic [31:0] hash2, nonce2;
   logic [31:0] dout;
   logic        empty, full, overflow;
   logic [3:0]  count;
   logic [7:0]  drop_count;
   logic [31:0] hit_count;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp_hits = 0;

   golden_nonce_fifo dut (
      .clk(clk), .reset(reset), .hash2(hash2), .nonce2(nonce2),
      .clear(clear), .rd_en(rd_en), .dout(dout), .empty(empty),
      .full(full), .count(count), .overflow(overflow),
      .drop_count(drop_count), .hit_count(hit_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every pop the DUT will accept must show the queue head.
   always @(negedge clk) begin
      if (reset && !clear && rd_en && !empty) begin
         if (exp_q.size() == 0) chk("unexpected_pop", dout, 32'hxxxxxxxx);
         else chk("dout_pop", dout, exp_q.pop_front());
      end
   end

   // One cycle of stimulus; returns #1 after the edge that consumes it.
   task automatic step(input logic h, input logic [31:0] n, input logic rd, input logic clr);
      hash2  = h ? MV : 32'h0;
      nonce2 = n;
      rd_en  = rd;
      clear  = clr;
      @(posedge clk);
      #1;
      hash2 = 32'h0; rd_en = 1'b0; clear = 1'b0;
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
   endtask

   initial begin
      reset = 1'b0; clear = 1'b0; rd_en = 1'b0; hash2 = 32'h0; nonce2 = 32'h0;
      @(posedge clk); @(posedge clk); #1;
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_drop", 32'(drop_count), 32'd0);
      chk("rst_hits", hit_count, 32'd0);
      reset = 1'b1;

      // Read while empty is ignored; a near-miss hash is not a hit.
      step(1'b0, 32'h0, 1'b1, 1'b0);
      hash2 = MV ^ 32'h1; nonce2 = 32'h55; @(posedge clk); #1; hash2 = 32'h0;
      chk("nohit_count", 32'(count), 32'd0);
      chk("nohit_hits", hit_count, 32'd0);

      // Single hit
      step(1'b1, 32'h00001234, 1'b0, 1'b0); exp_q.push_back(32'h00001234); exp_hits++;
      chk("single_empty", 32'(empty), 32'd0);
      chk("single_dout", dout, 32'h00001234);
      chk("single_count", 32'(count), 32'd1);
      chk("single_hits", hit_count, exp_hits);
      drain(1);
      chk("single_empty_after", 32'(empty), 32'd1);

      // Fill and overflow: 10 hits into 8 slots
      for (int i = 1; i <= 10; i++) begin
         step(1'b1, 32'(i), 1'b0, 1'b0);
         exp_hits++;
         if (i <= 8) exp_q.push_back(32'(i));
      end
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_count", 32'(count), 32'd8);
      chk("fill_overflow", 32'(overflow), 32'd1);
      chk("fill_drop", 32'(drop_count), 32'd2);
      chk("fill_hits", hit_count, exp_hits);
      drain(8);
      chk("fill_drained", 32'(empty), 32'd1);
      chk("overflow_sticky", 32'(overflow), 32'd1);
      step(1'b0, 32'h0, 1'b0, 1'b1);
      chk("clr_overflow", 32'(overflow), 32'd0);
      chk("clr_drop", 32'(drop_count), 32'd0);

      // Push and pop at full: no drop
      for (int i = 1; i <= 8; i++) begin
         step(1'b1, 32'(i), 1'b0, 1'b0); exp_q.push_back(32'(i)); exp_hits++;
      end
      step(1'b1, 32'd9, 1'b1, 1'b0); exp_q.push_back(32'd9); exp_hits++;
      chk("pp_count", 32'(count), 32'd8);
      chk("pp_full", 32'(full), 32'd1);
      chk("pp_overflow", 32'(overflow), 32'd0);
      chk("pp_drop", 32'(drop_count), 32'd0);
      drain(8);
      chk("pp_drained", 32'(count), 32'd0);

      // Streaming push+pop to wrap the pointers twice more
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 32'h100 + 32'(i), 1'b1, 1'b0); exp_q.push_back(32'h100 + 32'(i)); exp_hits++;
      end
      chk("wrap_count", 32'(count), 32'd1);
      chk("wrap_dout", dout, 32'h10f);
      chk("wrap_hits", hit_count, exp_hits);
      // Clear with a simultaneous hit: nothing stored, hit_count kept
      step(1'b1, 32'hcafe, 1'b0, 1'b1); exp_q.delete();
      chk("clr_count", 32'(count), 32'd0);
      chk("clr_empty", 32'(empty), 32'd1);
      chk("clr_drop2", 32'(drop_count), 32'd0);
      chk("clr_hits", hit_count, exp_hits);

      // drop_count saturation
      for (int i = 0; i < 268; i++) begin
         step(1'b1, 32'h200 + 32'(i), 1'b0, 1'b0); exp_hits++;
         if (i < 8) exp_q.push_back(32'h200 + 32'(i));
      end
      chk("sat_drop", 32'(drop_count), 32'd255);
      chk("sat_hits", hit_count, exp_hits);
      drain(8);
      step(1'b0, 32'h0, 1'b0, 1'b1);

      // Held match with the same nonce
      for (int i = 0; i < 3; i++) step(1'b1, 32'hdeadbeef, 1'b0, 1'b0);
`ifdef GOLDEN_NONCE_FIFO_DEDUP_EN
      exp_q.push_back(32'hdeadbeef); exp_hits++;
      chk("dedup_count", 32'(count), 32'd1);
`else
      for (int i = 0; i < 3; i++) begin exp_q.push_back(32'hdeadbeef); exp_hits++; end
      chk("dedup_count", 32'(count), 32'd3);
`endif
      chk("dedup_hits", hit_count, exp_hits);
      drain(3);
      chk("final_empty", 32'(empty), 32'd1);
      chk("final_queue", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
